vector_mask_tail_pipe: RTL and testbench
========================================

// Module: vector_mask_tail_pipe
// PURPOSE
// - Write-back-stage masking/tail engine for one vector register group, a parametrised, sequential successor to the combinational byte masker.
// - Takes one config per instruction, then DATA_WIDTH-bit result beats over a valid/ready stream.
// - Classifies each element as prestart, active, inactive or tail (RVV rules) and emits masked data plus per-byte write enables to the VRF write port.
// PARAMETERS
// - DATA_WIDTH  64   beat width in bits; multiple of 64
// - VLEN        256  register bits; multiple of DATA_WIDTH; BEATS = VLEN/DATA_WIDTH
// - TAG_WIDTH   5    destination tag width
// PORTS
// - clk          in   1             clock
// - rst_n        in   1             synchronous reset, active-low
// - cfg_valid    in   1             config offered
// - cfg_ready    out  1             config accepted (IDLE only)
// - cfg_sew      in   2             0=e8 1=e16 2=e32 3=e64
// - cfg_vl       in   $clog2(VLEN/8)+1   vector length
// - cfg_vstart   in   $clog2(VLEN/8)+1   first body element
// - cfg_vm       in   1             1=unmasked, 0=masked by cfg_v0
// - cfg_vta      in   1             tail agnostic
// - cfg_vma      in   1             mask agnostic
// - cfg_v0       in   VLEN/8        mask bits, bit i = element i
// - in_valid     in   1             result beat offered
// - in_ready     out  1             result beat accepted
// - in_data      in   DATA_WIDTH    result beat
// - in_tag       in   TAG_WIDTH     destination tag
// - in_old       in   DATA_WIDTH    old vd beat (only with VMTP_UNDISTURBED_MERGE_EN)
// - out_valid    out  1             output beat valid
// - out_ready    in   1             downstream accepts
// - out_data     out  DATA_WIDTH    masked beat
// - out_byte_en  out  DATA_WIDTH/8   per-byte write enable
// - out_tag      out  TAG_WIDTH     tag, passed through
// - out_last     out  1             final beat of the group
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE; out_valid, out_last, out_data, out_byte_en, out_tag = 0. Reset mid-operation drops the held beat and in-flight state; no partial recovery.
// - Control outputs: cfg_ready and in_ready are 0 while rst_n=0.
// - FSM IDLE:
//   - cfg_ready=1, in_ready=0.
//   - On cfg_valid: latch all cfg_*, elem_base=0, beat_cnt=0, then go to BUSY.
// - FSM BUSY:
//   - cfg_ready=0; in_ready = !out_valid || out_ready.
//   - On each accepted beat: register the output (latency 1 cycle), elem_base += EPB, beat_cnt++.
//   - EPB = DATA_WIDTH/(8<<sew).
//   - Accepting beat_cnt==BEATS-1 sets out_last=1 and returns to IDLE.
// - Output hold: out_* are stable while out_valid && !out_ready. out_valid clears on a handshake with no new beat accepted.
// - Element idx = elem_base + lane. All bytes of an element share its class:
//   - prestart (idx < vstart): undisturbed.
//   - tail (idx >= vl): agnostic if vta, else undisturbed.
//   - body, active (vm=1, or v0[idx]=1): byte_en=1, data=in_data.
//   - body, inactive: agnostic if vma, else undisturbed.
//   - agnostic: byte_en=1, data=all ones.
//   - undisturbed: see CONFIGURATION.
// - vl > VLEN/(8<<sew) is clamped to VLMAX.
// - vstart >= vl: every byte_en=0 for all BEATS (no tail write); beats are still consumed and out_last is still generated.
// - Mask bits are indexed by element, not byte (e32: 2 bits/beat when DATA_WIDTH=64). cfg_v0 bits beyond VLMAX are ignored.
// - In IDLE, a new config may be accepted while the last beat is still held in the output register.
// CONFIGURATION
// - Macro VMTP_UNDISTURBED_MERGE_EN.
// - Defined: port in_old exists; undisturbed bytes give byte_en=1, data=in_old byte, so every beat is a full write.
// - Undefined: no in_old port; undisturbed bytes give byte_en=0, data=in_data byte (VRF keeps the old value).
// TESTING (DATA_WIDTH=64, VLEN=256, BEATS=4, macro undefined unless stated)
// - Tail: sew=2 vl=5 vm=1 vta=1.
//   - Beats 0-1: byte_en=FF, data passthrough.
//   - Beat 2: data[31:0]=in, [63:32]=FFFFFFFF, byte_en=FF.
//   - Beat 3: all ones, out_last=1.
// - Mask: sew=0 vl=32 vm=0 vma=0 v0[7:0]=A5.
//   - Beat 0: byte_en=A5.
//   - With macro and in_old=0: out_data bytes 1,3,4,6 = 00, byte_en=FF.
// - vstart: sew=1 vstart=3 vl=8 vta=0.
//   - Beat 0: byte_en=C0.
//   - Beat 1: byte_en=FF.
//   - Beats 2-3: byte_en=00.
// - Backpressure: out_ready=0 for 3 cycles mid-group -> out_* held, in_ready=0, 4 beats emitted in order, no loss or duplicate.
// - Reset mid-op: rst_n=0 after beat 1 -> next cycle out_valid=0, cfg_ready=1; a new config restarts at element 0.
// - Empty body: vstart=4 vl=4 vta=1 -> 4 beats all byte_en=00, out_last on beat 3.

Source files
------------

// File: rtl/vector_mask_tail_pipe.sv
// Write-back masking/tail engine: classifies each element as prestart/active/inactive/tail and
// emits masked beats with per-byte write enables. Optional macro: VMTP_UNDISTURBED_MERGE_EN.
`timescale 1ns/1ps
module vector_mask_tail_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int VLEN       = 256,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [1:0]                cfg_sew,
  input  logic [$clog2(VLEN/8):0]   cfg_vl,
  input  logic [$clog2(VLEN/8):0]   cfg_vstart,
  input  logic                      cfg_vm,
  input  logic                      cfg_vta,
  input  logic                      cfg_vma,
  input  logic [VLEN/8-1:0]         cfg_v0,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [TAG_WIDTH-1:0]      in_tag,
`ifdef VMTP_UNDISTURBED_MERGE_EN
  input  logic [DATA_WIDTH-1:0]     in_old,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [DATA_WIDTH/8-1:0]   out_byte_en,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      out_last,
  output logic                      dbg_state
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int BEATS = VLEN / DATA_WIDTH;
  localparam int VL_W  = $clog2(VLEN/8) + 1;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // ready never depends on valid of the same channel.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  state_t state_q, state_d;

  logic [1:0]        sew_q;
  logic [VL_W-1:0]   vl_q, vstart_q, elem_base_q;
  logic              vm_q, vta_q, vma_q;
  logic [VLEN/8-1:0] v0_q;
  logic [BC_W-1:0]   beat_cnt_q;
  logic              cfg_fire, in_fire, last_beat;
  logic [VL_W-1:0]   vlmax, vl_clamped, epb;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic [NB-1:0]         nxt_be;

  assign cfg_fire   = cfg_valid && cfg_ready;
  assign in_fire    = in_valid && in_ready;
  assign last_beat  = (beat_cnt_q == BC_W'(BEATS-1));
  assign vlmax      = VL_W'((VLEN/8) >> cfg_sew);
  assign vl_clamped = (cfg_vl > vlmax) ? vlmax : cfg_vl;
  assign epb        = VL_W'(NB >> sew_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_fire) state_d = BUSY;
      BUSY:    if (in_fire && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = rst_n && (state_q == IDLE);
    in_ready  = rst_n && (state_q == BUSY) && (!out_valid || out_ready);
    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sew_q       <= '0;
      vl_q        <= '0;
      vstart_q    <= '0;
      vm_q        <= 1'b0;
      vta_q       <= 1'b0;
      vma_q       <= 1'b0;
      v0_q        <= '0;
      elem_base_q <= '0;
      beat_cnt_q  <= '0;
    end else if (cfg_fire) begin
      sew_q       <= cfg_sew;
      vl_q        <= vl_clamped;
      vstart_q    <= cfg_vstart;
      vm_q        <= cfg_vm;
      vta_q       <= cfg_vta;
      vma_q       <= cfg_vma;
      v0_q        <= cfg_v0;
      elem_base_q <= '0;
      beat_cnt_q  <= '0;
    end else if (in_fire) begin
      elem_base_q <= elem_base_q + epb;
      beat_cnt_q  <= beat_cnt_q + 1'b1;
    end
  end

  // Every byte inherits the class of the element it belongs to.
  always_comb begin
    logic [VL_W-1:0] idx;
    logic undist, agn;
    nxt_data = in_data;
    nxt_be   = '0;
    idx      = '0;
    undist   = 1'b0;
    agn      = 1'b0;
    for (int b = 0; b < NB; b++) begin
      idx    = elem_base_q + VL_W'(b >> sew_q);
      undist = 1'b0;
      agn    = 1'b0;
      if (vstart_q >= vl_q)                undist = 1'b0;
      else if (idx < vstart_q)             undist = 1'b1;
      else if (idx >= vl_q)                begin agn = vta_q; undist = !vta_q; end
      else if (!vm_q && !v0_q[idx[VL_W-2:0]]) begin agn = vma_q; undist = !vma_q; end
      else                                 nxt_be[b] = 1'b1;
      if (agn) begin
        nxt_be[b]          = 1'b1;
        nxt_data[8*b +: 8] = 8'hFF;
      end
`ifdef VMTP_UNDISTURBED_MERGE_EN
      if (undist) begin
        nxt_be[b]          = 1'b1;
        nxt_data[8*b +: 8] = in_old[8*b +: 8];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      out_byte_en <= '0;
      out_tag     <= '0;
    end else if (in_fire) begin
      out_valid   <= 1'b1;
      out_last    <= last_beat;
      out_data    <= nxt_data;
      out_byte_en <= nxt_be;
      out_tag     <= in_tag;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vector_mask_tail_pipe.sv
// Directed bench for vector_mask_tail_pipe (DATA_WIDTH=64, VLEN=256, merge macro undefined).
`timescale 1ns/1ps
module tb_vector_mask_tail_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_sew;
  logic [5:0]  cfg_vl, cfg_vstart;
  logic        cfg_vm, cfg_vta, cfg_vma;
  logic [31:0] cfg_v0;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready, out_last, dbg_state;
  logic [63:0] out_data;
  logic [7:0]  out_byte_en;
  logic [4:0]  out_tag;

  int checks = 0;
  int errors = 0;
  logic [63:0] beat_data [4];
  logic [63:0] obs_data  [4];
  logic [7:0]  obs_be    [4];
  logic        obs_last  [4];
  logic        obs_valid [4];
  logic [4:0]  obs_tag   [4];
  logic [63:0] exp_q [$];

  vector_mask_tail_pipe #(.DATA_WIDTH(64), .VLEN(256), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sew(cfg_sew), .cfg_vl(cfg_vl),
    .cfg_vstart(cfg_vstart), .cfg_vm(cfg_vm), .cfg_vta(cfg_vta), .cfg_vma(cfg_vma), .cfg_v0(cfg_v0),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_byte_en(out_byte_en),
    .out_tag(out_tag), .out_last(out_last), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic send_cfg(input logic [1:0] sew, input logic [5:0] vl, input logic [5:0] vstart,
                          input logic vm, input logic vta, input logic vma, input logic [31:0] v0);
    int n;
    @(negedge clk);
    cfg_sew = sew; cfg_vl = vl; cfg_vstart = vstart;
    cfg_vm = vm; cfg_vta = vta; cfg_vma = vma; cfg_v0 = v0;
    cfg_valid = 1'b1;
    #1;
    n = 0;
    while (!cfg_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!cfg_ready) begin
      checks++; errors++;
      $display("FAIL cfg_timeout: cfg_ready got 0 exp 1");
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic stream_group(input int nbeats, input logic [4:0] tag);
    int n;
    out_ready = 1'b1;
    for (int k = 0; k < nbeats; k++) begin
      in_valid = 1'b1; in_data = beat_data[k]; in_tag = tag;
      #1;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL beat_timeout[%0d]: in_ready got 0 exp 1", k);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      obs_valid[k] = out_valid; obs_data[k] = out_data; obs_be[k] = out_byte_en;
      obs_last[k] = out_last; obs_tag[k] = out_tag;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_data, out_byte_en, out_tag} !== 79'd0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0", {out_valid, out_last, out_data, out_byte_en, out_tag});
    end
    checks++;
    if ({cfg_ready, in_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b exp 00", {cfg_ready, in_ready});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({cfg_ready, in_ready} !== 2'b10) begin
      errors++; $display("FAIL idle_ready: got %b exp 10", {cfg_ready, in_ready});
    end
  endtask

  task automatic test_tail();
    logic [63:0] exp_d [4];
    for (int k = 0; k < 4; k++) beat_data[k] = 64'h1111_2222_3333_4440 + 64'(k);
    exp_d[0] = beat_data[0];
    exp_d[1] = beat_data[1];
    exp_d[2] = {32'hFFFF_FFFF, beat_data[2][31:0]};
    exp_d[3] = '1;
    send_cfg(2'd2, 6'd5, 6'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    stream_group(4, 5'd17);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_data[k] !== exp_d[k]) begin
        errors++; $display("FAIL tail_data[%0d]: got %h exp %h", k, obs_data[k], exp_d[k]);
      end
      checks++;
      if ({obs_valid[k], obs_be[k], obs_last[k], obs_tag[k]} !== {1'b1, 8'hFF, (k == 3), 5'd17}) begin
        errors++; $display("FAIL tail_ctl[%0d]: got v=%b be=%h last=%b tag=%0d exp v=1 be=ff last=%0d tag=17",
                           k, obs_valid[k], obs_be[k], obs_last[k], obs_tag[k], (k == 3));
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, cfg_ready} !== 2'b01) begin
      errors++; $display("FAIL tail_drain: got valid,cfg_ready=%b exp 01", {out_valid, cfg_ready});
    end
  endtask

  task automatic test_mask();
    logic [7:0] exp_be [4];
    exp_be[0] = 8'hA5; exp_be[1] = 8'hFF; exp_be[2] = 8'h0F; exp_be[3] = 8'h3C;
    for (int k = 0; k < 4; k++) beat_data[k] = 64'h0123_4567_89AB_CDE0 ^ 64'(k * 3);
    send_cfg(2'd0, 6'd32, 6'd0, 1'b0, 1'b0, 1'b0, 32'h3C0F_FFA5);
    stream_group(4, 5'd3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({obs_be[k], obs_data[k], obs_last[k]} !== {exp_be[k], beat_data[k], (k == 3)}) begin
        errors++; $display("FAIL mask[%0d]: got be=%h d=%h last=%b exp be=%h d=%h last=%0d",
                           k, obs_be[k], obs_data[k], obs_last[k], exp_be[k], beat_data[k], (k == 3));
      end
    end
  endtask

  task automatic test_vstart();
    logic [7:0] exp_be [4];
    exp_be[0] = 8'hC0; exp_be[1] = 8'hFF; exp_be[2] = 8'h00; exp_be[3] = 8'h00;
    for (int k = 0; k < 4; k++) beat_data[k] = 64'hDEAD_BEEF_0000_0000 + 64'(k);
    send_cfg(2'd1, 6'd8, 6'd3, 1'b1, 1'b0, 1'b1, 32'h0);
    stream_group(4, 5'd9);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({obs_be[k], obs_last[k]} !== {exp_be[k], (k == 3)}) begin
        errors++; $display("FAIL vstart[%0d]: got be=%h last=%b exp be=%h last=%0d",
                           k, obs_be[k], obs_last[k], exp_be[k], (k == 3));
      end
    end
  endtask

  task automatic test_empty_body();
    for (int k = 0; k < 4; k++) beat_data[k] = 64'hFFFF_0000_FFFF_0000 + 64'(k);
    send_cfg(2'd0, 6'd4, 6'd4, 1'b1, 1'b1, 1'b1, 32'h0);
    stream_group(4, 5'd1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({obs_valid[k], obs_be[k], obs_last[k]} !== {1'b1, 8'h00, (k == 3)}) begin
        errors++; $display("FAIL empty[%0d]: got v=%b be=%h last=%b exp v=1 be=00 last=%0d",
                           k, obs_valid[k], obs_be[k], obs_last[k], (k == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    int sent, got;
    logic [63:0] held;
    logic stalled;
    logic [63:0] e;
    for (int k = 0; k < 4; k++) beat_data[k] = 64'hA000_0000_0000_0001 << k;
    send_cfg(2'd3, 6'd4, 6'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    exp_q.delete();
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (c > 0) @(negedge clk);
      out_ready = !(c >= 3 && c < 6);
      in_valid  = (sent < 4);
      in_data   = beat_data[sent % 4];
      in_tag    = 5'd5;
      #1;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b exp 0", c, in_ready); end
        if (stalled) begin
          checks++;
          if (out_data !== held) begin errors++; $display("FAIL bp_hold[%0d]: got %h exp %h", c, out_data, held); end
        end
        stalled = 1'b1; held = out_data;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got %h exp none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e || out_last !== (got == 3)) begin
            errors++; $display("FAIL bp_beat[%0d]: got %h last=%b exp %h last=%0d", got, out_data, out_last, e, (got == 3));
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(in_data); sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 4 || !stalled) begin errors++; $display("FAIL bp_count: got %0d stalled=%b exp 4 stalled=1", got, stalled); end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] exp_be [4];
    exp_be[0] = 8'hFF; exp_be[1] = 8'h00; exp_be[2] = 8'hFF; exp_be[3] = 8'h00;
    for (int k = 0; k < 4; k++) beat_data[k] = 64'h5555_0000_0000_0000 + 64'(k);
    send_cfg(2'd3, 6'd4, 6'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    stream_group(2, 5'd7);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, cfg_ready, in_ready} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_low: got %b exp 000", {out_valid, cfg_ready, in_ready});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({out_valid, cfg_ready} !== 2'b01) begin
      errors++; $display("FAIL rst_mid_idle: got %b exp 01", {out_valid, cfg_ready});
    end
    send_cfg(2'd3, 6'd4, 6'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0005);
    stream_group(4, 5'd8);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({obs_be[k], obs_last[k]} !== {exp_be[k], (k == 3)}) begin
        errors++; $display("FAIL rst_restart[%0d]: got be=%h last=%b exp be=%h last=%0d",
                           k, obs_be[k], obs_last[k], exp_be[k], (k == 3));
      end
    end
  endtask

  initial begin
    cfg_valid = 1'b0; cfg_sew = '0; cfg_vl = '0; cfg_vstart = '0;
    cfg_vm = 1'b1; cfg_vta = 1'b0; cfg_vma = 1'b0; cfg_v0 = '0;
    in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    test_reset();
    test_tail();
    test_mask();
    test_vstart();
    test_empty_body();
    test_backpressure();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
